// File: rtl/alu_filter_iir_casc_if.sv
// Bus bundle for the cascaded biquad filter: frame in/out handshake,
// coefficient load and the flat DSP48A1 operand/result bus.
interface alu_filter_iir_casc_if #(
  parameter int NUM_CH   = 2,
  parameter int NUM_SECT = 2
);
  logic [NUM_SECT*90-1:0] coefs_flat;
  logic [NUM_CH*18-1:0]   sample_in;
  logic                   sample_in_rdy;
  logic [NUM_CH*18-1:0]   sample_out;
  logic                   sample_out_rdy;
  logic                   busy;
  logic                   overrun;
  logic                   sat_flag;
  logic [47:0]            dsp_outs_flat;
  logic [91:0]            dsp_ins_flat;

  // Environment side: supplies frames, coefficients and the DSP result.
  modport master (
    output coefs_flat, sample_in, sample_in_rdy, dsp_outs_flat,
    input  sample_out, sample_out_rdy, busy, overrun, sat_flag, dsp_ins_flat
  );

  // Filter side.
  modport slave (
    input  coefs_flat, sample_in, sample_in_rdy, dsp_outs_flat,
    output sample_out, sample_out_rdy, busy, overrun, sat_flag, dsp_ins_flat
  );
endinterface

// File: rtl/alu_filter_iir_casc.sv
// Multi-channel cascaded direct-form-I biquad IIR filter. One external
// DSP48A1 slice is time-shared: every (channel, section) job issues five
// multiply(-accumulate) ops, waits for the DSP pipeline, then saturates P.
module alu_filter_iir_casc #(
  parameter int NUM_CH    = 2,
  parameter int NUM_SECT  = 2,
  parameter int COEF_FRAC = 16,
  parameter int DSP_LAT   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_filter_iir_casc_if.slave    bus
);
  localparam int CH_W   = (NUM_CH   > 1) ? $clog2(NUM_CH)   : 1;
  localparam int SECT_W = (NUM_SECT > 1) ? $clog2(NUM_SECT) : 1;
  localparam int LAT_W  = (DSP_LAT  > 1) ? $clog2(DSP_LAT)  : 1;
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [SECT_W-1:0] SECT_LAST = SECT_W'(NUM_SECT - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(DSP_LAT - 1);

  // DSP48A1 opmode fields: X mux in [1:0], Z mux in [3:2].
  localparam logic [7:0] DSP_NOP      = 8'h00;
  localparam logic [7:0] DSP_XIN_MULT = 8'h01;
  localparam logic [7:0] DSP_ZIN_ZERO = 8'h00;
  localparam logic [7:0] DSP_ZIN_POUT = 8'h08;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAC    = 3'd1,
    S_WAIT_P = 3'd2,
    S_STORE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          k_q, k_d;
  logic [LAT_W-1:0]    w_q, w_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [SECT_W-1:0]   sect_q, sect_d;
  logic [7:0]          op_q, op_d;
  logic [17:0]         a_q, a_d, b_q, b_d;
  logic                rdy_q, rdy_d, busy_q, busy_d, ovr_q, ovr_d;
  logic                cap_s, store_s;

  logic [17:0] smp_q  [NUM_CH];
  logic [17:0] coef_q [NUM_SECT][5];
  logic [17:0] x1_q   [NUM_CH][NUM_SECT];
  logic [17:0] x2_q   [NUM_CH][NUM_SECT];
  logic [17:0] y1_q   [NUM_CH][NUM_SECT];
  logic [17:0] y2_q   [NUM_CH][NUM_SECT];
  logic [17:0] outreg_q [NUM_CH];
  logic [17:0] xin_q;
  logic [NUM_CH*18-1:0] sample_out_q;
  logic        sat_q;

  logic [17:0] xin_s, opnd_s, coef_s, y_s;
  logic        ovf_s;
  logic [47-(COEF_FRAC+17):0] p_hi_s;

  // Section input: the channel sample for section 0, else the previous section's output.
  always_comb begin
    xin_s = xin_q;
    if (sect_q == {SECT_W{1'b0}}) begin
      xin_s = smp_q[ch_q];
    end else begin
      xin_s = xin_q;
    end
  end

  // Operand/coefficient select for MAC step k: {xin,x1,x2,y1,y2} against {b0,b1,b2,-a1,-a2}.
  always_comb begin
    opnd_s = xin_s;
    coef_s = coef_q[sect_q][0];
    case (k_q)
      3'd0: begin opnd_s = xin_s;              coef_s = coef_q[sect_q][0]; end
      3'd1: begin opnd_s = x1_q[ch_q][sect_q]; coef_s = coef_q[sect_q][1]; end
      3'd2: begin opnd_s = x2_q[ch_q][sect_q]; coef_s = coef_q[sect_q][2]; end
      3'd3: begin opnd_s = y1_q[ch_q][sect_q]; coef_s = coef_q[sect_q][3]; end
      default: begin opnd_s = y2_q[ch_q][sect_q]; coef_s = coef_q[sect_q][4]; end
    endcase
  end

  // Saturate P to 18 bits: any disagreement among the bits above the slice is overflow.
  always_comb begin
    p_hi_s = bus.dsp_outs_flat[47:COEF_FRAC+17];
    ovf_s  = !((&p_hi_s) || !(|p_hi_s));
    if (ovf_s) begin
      y_s = bus.dsp_outs_flat[47] ? 18'h20000 : 18'h1FFFF;
    end else begin
      y_s = bus.dsp_outs_flat[COEF_FRAC+17:COEF_FRAC];
    end
  end

  // Next-state and registered-output logic of the job sequencer.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    w_d     = w_q;
    ch_d    = ch_q;
    sect_d  = sect_q;
    op_d    = DSP_NOP;
    a_d     = 18'd0;
    b_d     = 18'd0;
    rdy_d   = 1'b0;
    cap_s   = 1'b0;
    store_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.sample_in_rdy) begin
          cap_s   = 1'b1;
          ch_d    = {CH_W{1'b0}};
          sect_d  = {SECT_W{1'b0}};
          k_d     = 3'd0;
          state_d = S_MAC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        op_d = (k_q == 3'd0) ? (DSP_XIN_MULT | DSP_ZIN_ZERO) : (DSP_XIN_MULT | DSP_ZIN_POUT);
        a_d  = coef_s;
        b_d  = opnd_s;
        if (k_q == 3'd4) begin
          k_d     = 3'd0;
          w_d     = {LAT_W{1'b0}};
          state_d = S_WAIT_P;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_WAIT_P: begin
        if (w_q == LAT_LAST) begin
          state_d = S_STORE;
        end else begin
          w_d = w_q + {{(LAT_W-1){1'b0}}, 1'b1};
        end
      end
      S_STORE: begin
        store_s = 1'b1;
        if (sect_q != SECT_LAST) begin
          sect_d  = sect_q + {{(SECT_W-1){1'b0}}, 1'b1};
          state_d = S_MAC;
        end else if (ch_q != CH_LAST) begin
          sect_d  = {SECT_W{1'b0}};
          ch_d    = ch_q + {{(CH_W-1){1'b0}}, 1'b1};
          state_d = S_MAC;
        end else begin
          sect_d  = {SECT_W{1'b0}};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    ovr_d  = bus.sample_in_rdy && (state_q != S_IDLE);
  end

  // Sequencer state and DSP operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
      w_q     <= {LAT_W{1'b0}};
      ch_q    <= {CH_W{1'b0}};
      sect_q  <= {SECT_W{1'b0}};
      op_q    <= DSP_NOP;
      a_q     <= 18'd0;
      b_q     <= 18'd0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      w_q     <= w_d;
      ch_q    <= ch_d;
      sect_q  <= sect_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame capture, per-section delay lines, output registers and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        smp_q[c]    <= 18'd0;
        outreg_q[c] <= 18'd0;
        for (int s = 0; s < NUM_SECT; s++) begin
          x1_q[c][s] <= 18'd0;
          x2_q[c][s] <= 18'd0;
          y1_q[c][s] <= 18'd0;
          y2_q[c][s] <= 18'd0;
        end
      end
      for (int s = 0; s < NUM_SECT; s++) begin
        for (int k = 0; k < 5; k++) begin
          coef_q[s][k] <= 18'd0;
        end
      end
      xin_q        <= 18'd0;
      sample_out_q <= '0;
      sat_q        <= 1'b0;
    end else begin
      if (cap_s) begin
        for (int c = 0; c < NUM_CH; c++) begin
          smp_q[c] <= bus.sample_in[18*c +: 18];
        end
        for (int s = 0; s < NUM_SECT; s++) begin
          for (int k = 0; k < 5; k++) begin
            coef_q[s][k] <= bus.coefs_flat[90*s + 18*k +: 18];
          end
        end
      end
      if (store_s) begin
        x2_q[ch_q][sect_q] <= x1_q[ch_q][sect_q];
        x1_q[ch_q][sect_q] <= xin_s;
        y2_q[ch_q][sect_q] <= y1_q[ch_q][sect_q];
        y1_q[ch_q][sect_q] <= y_s;
        xin_q              <= y_s;
        if (sect_q == SECT_LAST) begin
          outreg_q[ch_q] <= y_s;
        end
        if (ovf_s) begin
          sat_q <= 1'b1;
        end
      end
      if (state_q == S_DONE) begin
        for (int c = 0; c < NUM_CH; c++) begin
          sample_out_q[18*c +: 18] <= outreg_q[c];
        end
      end
    end
  end

  assign bus.sample_out     = sample_out_q;
  assign bus.sample_out_rdy = rdy_q;
  assign bus.busy           = busy_q;
  assign bus.overrun        = ovr_q;
  assign bus.sat_flag       = sat_q;
  assign bus.dsp_ins_flat   = {op_q, a_q, b_q, 48'd0};
endmodule

// File: tb/tb_alu_filter_iir_casc.sv
// Scoreboard bench for alu_filter_iir_casc: a behavioural DSP48A1 model
// closes the DSP bus, an arithmetic reference model predicts each frame.
module tb_alu_filter_iir_casc;
  localparam int NC  = 2;
  localparam int NS  = 2;
  localparam int FR  = 16;
  localparam int LAT = 2;
  localparam int L   = NC*NS*(6+LAT)+1;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_MUL = 8'h01;
  localparam logic [7:0] OP_MAC = 8'h09;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_filter_iir_casc_if #(.NUM_CH(NC), .NUM_SECT(NS)) bus_if ();
  alu_filter_iir_casc #(.NUM_CH(NC), .NUM_SECT(NS), .COEF_FRAC(FR), .DSP_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus_if)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_count = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DSP48A1 behaviour: one input register stage, then P (two clocks a/b/opmode -> P).
  logic [7:0]         d_op = 8'h00;
  logic signed [17:0] d_a = 18'sd0, d_b = 18'sd0;
  logic signed [47:0] d_p = 48'sd0;
  function automatic logic signed [47:0] prod48(input logic signed [17:0] a, input logic signed [17:0] b);
    longint m;
    m = longint'(a) * longint'(b);
    return 48'(m);
  endfunction
  always @(posedge clk) begin
    d_op <= bus_if.dsp_ins_flat[91:84];
    d_a  <= bus_if.dsp_ins_flat[83:66];
    d_b  <= bus_if.dsp_ins_flat[65:48];
    if (d_op == OP_MUL) d_p <= prod48(d_a, d_b);
    else if (d_op == OP_MAC) d_p <= d_p + prod48(d_a, d_b);
  end
  assign bus_if.dsp_outs_flat = d_p;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: difference equation per channel/section with plain integers.
  longint hx1[NC][NS], hx2[NC][NS], hy1[NC][NS], hy2[NC][NS];
  bit m_sat = 1'b0;

  function automatic longint sx(input logic [17:0] v);
    logic signed [17:0] t;
    t = v;
    return longint'(t);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < NS; s++) begin
        hx1[c][s] = 0; hx2[c][s] = 0; hy1[c][s] = 0; hy2[c][s] = 0;
      end
    m_sat = 1'b0;
  endtask

  task automatic model_frame(input logic [NC*18-1:0] smp, input logic [NS*90-1:0] cf,
                             output logic [NC*18-1:0] out);
    out = '0;
    for (int c = 0; c < NC; c++) begin
      longint xin, acc, q;
      longint co[5];
      xin = sx(smp[18*c +: 18]);
      for (int s = 0; s < NS; s++) begin
        for (int k = 0; k < 5; k++) co[k] = sx(cf[90*s + 18*k +: 18]);
        acc = co[0]*xin + co[1]*hx1[c][s] + co[2]*hx2[c][s] + co[3]*hy1[c][s] + co[4]*hy2[c][s];
        q = acc >>> FR;
        if (q > 131071) begin q = 131071; m_sat = 1'b1; end
        else if (q < -131072) begin q = -131072; m_sat = 1'b1; end
        hx2[c][s] = hx1[c][s]; hx1[c][s] = xin;
        hy2[c][s] = hy1[c][s]; hy1[c][s] = q;
        xin = q;
      end
      out[18*c +: 18] = 18'(xin);
    end
  endtask

  typedef struct {
    logic [NC*18-1:0] out;
    bit               sat;
    int               cyc;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [89:0] sect(input logic [17:0] b0, input logic [17:0] b1, input logic [17:0] b2,
                                       input logic [17:0] na1, input logic [17:0] na2);
    return {na2, na1, b2, b1, b0};
  endfunction

  // Issue one frame at a negedge once the filter is idle and record its prediction.
  task automatic send(input logic [NC*18-1:0] smp, input logic [NS*90-1:0] cf);
    exp_t e;
    int n;
    n = 0;
    while (bus_if.busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin failures++; checks++; $display("FAIL send_wait: busy stuck got 1 expected 0"); end
    bus_if.sample_in     = smp;
    bus_if.coefs_flat    = cf;
    bus_if.sample_in_rdy = 1'b1;
    model_frame(smp, cf, e.out);
    e.sat = m_sat;
    e.cyc = cyc + L + 1;
    sbq.push_back(e);
    @(negedge clk);
    bus_if.sample_in_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || bus_if.busy) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin failures++; checks++; $display("FAIL wait_idle: timeout got %0d pending expected 0", sbq.size()); end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sbq.delete();
  endtask

  // Monitor: pop and compare whenever the DUT presents a frame.
  initial begin
    bit prev_rdy;
    exp_t e;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.sample_out_rdy) begin
        rdy_count++;
        chk("rdy_width", 64'(prev_rdy), 64'd0);
        if (sbq.size() == 0) begin
          failures++; checks++;
          $display("FAIL unexpected_rdy: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("sample_out", 64'(bus_if.sample_out), 64'(e.out));
          chk("sat_flag", 64'(bus_if.sat_flag), 64'(e.sat));
          chk("latency", 64'(cyc), 64'(e.cyc));
        end
      end
      prev_rdy = bus_if.sample_out_rdy;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS*90-1:0] cf_pass, cf_half, cf_rec, cf_sat, cf_rnd;
    int snap;
    bus_if.sample_in = '0;
    bus_if.coefs_flat = '0;
    bus_if.sample_in_rdy = 1'b0;
    model_reset();
    cf_pass = {sect(18'h10000, 18'h0, 18'h0, 18'h0, 18'h0), sect(18'h10000, 18'h0, 18'h0, 18'h0, 18'h0)};
    cf_half = {sect(18'h08000, 18'h0, 18'h0, 18'h0, 18'h0), sect(18'h08000, 18'h0, 18'h0, 18'h0, 18'h0)};
    cf_rec  = {sect(18'h10000, 18'h0, 18'h0, 18'h0, 18'h0), sect(18'h10000, 18'h0, 18'h0, 18'h08000, 18'h0)};
    cf_sat  = {sect(18'h10000, 18'h0, 18'h0, 18'h0, 18'h0), sect(18'h1FFFF, 18'h0, 18'h0, 18'h0, 18'h0)};

    repeat (3) @(negedge clk);
    chk("rst_sample_out", 64'(bus_if.sample_out), 64'd0);
    chk("rst_rdy", 64'(bus_if.sample_out_rdy), 64'd0);
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_sat", 64'(bus_if.sat_flag), 64'd0);
    chk("rst_dsp_ins", 64'(bus_if.dsp_ins_flat[91:48]), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Pass-through.
    send({18'h3FF00, 18'h01234}, cf_pass);
    chk("busy_running", 64'(bus_if.busy), 64'd1);
    wait_idle();
    chk("pass_out", 64'(bus_if.sample_out), 64'({18'h3FF00, 18'h01234}));

    // Cascade gain 0.5 * 0.5.
    send({18'h00000, 18'h10000}, cf_half);
    wait_idle();
    chk("gain_out", 64'(bus_if.sample_out), 64'({18'h00000, 18'h04000}));

    // Recursion y = x + 0.5*y1 from zero history; ch1 fed zeros.
    do_reset();
    send({18'h00000, 18'h10000}, cf_rec);
    wait_idle();
    chk("rec0", 64'(bus_if.sample_out), 64'({18'h00000, 18'h10000}));
    send('0, cf_rec);
    wait_idle();
    chk("rec1", 64'(bus_if.sample_out), 64'({18'h00000, 18'h08000}));
    send('0, cf_rec);
    wait_idle();
    chk("rec2", 64'(bus_if.sample_out), 64'({18'h00000, 18'h04000}));
    send('0, cf_rec);
    wait_idle();
    chk("rec3", 64'(bus_if.sample_out), 64'({18'h00000, 18'h02000}));

    // Saturation, positive then negative; flag sticks until reset.
    send({18'h00000, 18'h1FFFF}, cf_sat);
    wait_idle();
    chk("sat_pos", 64'(bus_if.sample_out[17:0]), 64'h1FFFF);
    chk("sat_flag_set", 64'(bus_if.sat_flag), 64'd1);
    send({18'h00000, 18'h20000}, cf_sat);
    wait_idle();
    chk("sat_neg", 64'(bus_if.sample_out[17:0]), 64'h20000);
    repeat (5) @(negedge clk);
    chk("sat_sticky", 64'(bus_if.sat_flag), 64'd1);
    do_reset();
    chk("sat_cleared", 64'(bus_if.sat_flag), 64'd0);

    // Overrun: second strobe 10 clocks into a frame is dropped.
    snap = rdy_count;
    send({18'h00555, 18'h00AAA}, cf_pass);
    repeat (9) @(negedge clk);
    bus_if.sample_in = {18'h01111, 18'h02222};
    bus_if.sample_in_rdy = 1'b1;
    @(negedge clk);
    bus_if.sample_in_rdy = 1'b0;
    chk("overrun_pulse", 64'(bus_if.overrun), 64'd1);
    @(negedge clk);
    chk("overrun_end", 64'(bus_if.overrun), 64'd0);
    wait_idle();
    repeat (L) @(negedge clk);
    chk("overrun_rdy_count", 64'(rdy_count - snap), 64'd1);
    chk("overrun_out", 64'(bus_if.sample_out), 64'({18'h00555, 18'h00AAA}));

    // Reset in the middle of a frame.
    send({18'h00000, 18'h10000}, cf_rec);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", 64'(bus_if.sample_out), 64'd0);
    chk("mid_rst_busy", 64'(bus_if.busy), 64'd0);
    chk("mid_rst_opmode", 64'(bus_if.dsp_ins_flat[91:84]), 64'(OP_NOP));
    chk("mid_rst_rdy", 64'(bus_if.sample_out_rdy), 64'd0);
    reset = 1'b0;
    model_reset();
    sbq.delete();
    snap = rdy_count;
    repeat (L + 10) @(negedge clk);
    chk("mid_rst_no_rdy", 64'(rdy_count - snap), 64'd0);
    send({18'h00000, 18'h10000}, cf_rec);
    wait_idle();
    chk("mid_rst_fresh", 64'(bus_if.sample_out), 64'({18'h00000, 18'h10000}));

    // Randomised frames with random coefficients in [-0.5, 0.5).
    for (int f = 0; f < 24; f++) begin
      if (f % 6 == 0) begin
        for (int s = 0; s < NS; s++)
          for (int k = 0; k < 5; k++)
            cf_rnd[90*s + 18*k +: 18] = 18'($urandom_range(0, 65535)) - 18'h08000;
      end
      send(36'($urandom) | {$urandom} << 32, cf_rnd);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
